// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: each output round-robin picks one requesting input
// and stays locked to it until that input's tail flit has crossed the crossbar.
module output_port_allocator #(
    parameter int NumberOfPorts  = 5,
    parameter int PortIndexWidth = 3
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic [NumberOfPorts-1:0]                 req_valid_i,
    input  logic [NumberOfPorts*NumberOfPorts-1:0]   req_port_i,
    input  logic [NumberOfPorts-1:0]                 req_tail_i,
    input  logic [NumberOfPorts-1:0]                 out_ready_i,
    output logic [NumberOfPorts-1:0]                 grant_o,
    output logic [NumberOfPorts*PortIndexWidth-1:0]  out_sel_o,
    output logic [NumberOfPorts-1:0]                 out_valid_o,
    output logic [NumberOfPorts-1:0]                 out_busy_o
);

    localparam int N = NumberOfPorts;
    localparam int W = PortIndexWidth;

    typedef enum logic {
        StIdle,
        StLocked
    } state_e;

    state_e         state_q  [N];
    state_e         state_d  [N];
    logic [W-1:0]   owner_q  [N];
    logic [W-1:0]   owner_d  [N];
    logic [W-1:0]   ptr_q    [N];
    logic [W-1:0]   ptr_d    [N];

    logic [N-1:0]   reqMask  [N];
    logic [N-1:0]   reqToOut [N];
    logic [W-1:0]   winner   [N];
    logic [N-1:0]   anyReq;
    logic [N-1:0]   ownsAny;
    logic [N-1:0]   transfer;
    logic [W-1:0]   scanIdx;

    // Keep only the lowest requested output of each valid input.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            reqMask[i] = '0;
            for (int o = N - 1; o >= 0; o--) begin
                if (req_port_i[i*N + o]) begin
                    reqMask[i]    = '0;
                    reqMask[i][o] = 1'b1;
                end
            end
            if (!req_valid_i[i]) begin
                reqMask[i] = '0;
            end
        end
    end

    // An input that already holds an output may not compete for another one.
    always_comb begin
        ownsAny = '0;
        for (int o = 0; o < N; o++) begin
            if (state_q[o] == StLocked) begin
                ownsAny[owner_q[o]] = 1'b1;
            end
        end
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                reqToOut[o][i] = reqMask[i][o] & ~ownsAny[i];
            end
        end
    end

    // Scan from farthest to nearest so the input closest after the pointer wins.
    always_comb begin
        scanIdx = '0;
        for (int o = 0; o < N; o++) begin
            anyReq[o] = 1'b0;
            winner[o] = '0;
            for (int k = N; k >= 1; k--) begin
                scanIdx = W'((int'(ptr_q[o]) + k) % N);
                if (reqToOut[o][scanIdx]) begin
                    anyReq[o] = 1'b1;
                    winner[o] = scanIdx;
                end
            end
        end
    end

    always_comb begin
        transfer = '0;
        for (int o = 0; o < N; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            case (state_q[o])
                StIdle: begin
                    if (anyReq[o]) begin
                        state_d[o] = StLocked;
                        owner_d[o] = winner[o];
                        ptr_d[o]   = winner[o];
                    end
                end
                StLocked: begin
                    transfer[o] = req_valid_i[owner_q[o]] & out_ready_i[o];
                    if (transfer[o] && req_tail_i[owner_q[o]]) begin
                        state_d[o] = StIdle;
                    end
                end
                default: state_d[o] = StIdle;
            endcase
        end
    end

    always_comb begin
        grant_o     = '0;
        out_valid_o = transfer;
        out_busy_o  = '0;
        out_sel_o   = '0;
        for (int o = 0; o < N; o++) begin
            out_sel_o[o*W +: W] = owner_q[o];
            if (state_q[o] == StLocked) begin
                out_busy_o[o]       = 1'b1;
                grant_o[owner_q[o]] = grant_o[owner_q[o]] | out_ready_i[o];
            end
        end
    end

    // Pointers reset to the last port so input 0 is favoured first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int o = 0; o < N; o++) begin
                state_q[o] <= StIdle;
                owner_q[o] <= '0;
                ptr_q[o]   <= W'(N - 1);
            end
        end else begin
            for (int o = 0; o < N; o++) begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

endmodule

// File: tb/tb_output_port_allocator.sv
// Directed bench for output_port_allocator; port indices used here:
// E=0, W=1, N=2, S=3, L=4.
module tb_output_port_allocator;

    localparam int PE = 0;
    localparam int PW = 1;
    localparam int PN = 2;
    localparam int PS = 3;
    localparam int PL = 4;
    localparam logic [4:0] mE = 5'b00001;
    localparam logic [4:0] mW = 5'b00010;
    localparam logic [4:0] mN = 5'b00100;
    localparam logic [4:0] mS = 5'b01000;
    localparam logic [4:0] mL = 5'b10000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [4:0]  req_valid_i = '0;
    logic [24:0] req_port_i = '0;
    logic [4:0]  req_tail_i = '0;
    logic [4:0]  out_ready_i = '0;
    logic [4:0]  grant_o;
    logic [14:0] out_sel_o;
    logic [4:0]  out_valid_o;
    logic [4:0]  out_busy_o;

    int checks = 0;
    int failures = 0;

    output_port_allocator #(
        .NumberOfPorts (5),
        .PortIndexWidth(3)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .req_valid_i(req_valid_i),
        .req_port_i (req_port_i),
        .req_tail_i (req_tail_i),
        .out_ready_i(out_ready_i),
        .grant_o    (grant_o),
        .out_sel_o  (out_sel_o),
        .out_valid_o(out_valid_o),
        .out_busy_o (out_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [4:0] slice, input logic tail, input logic valid);
        req_valid_i[idx]         = valid;
        req_port_i[idx*5 +: 5]   = slice;
        req_tail_i[idx]          = tail;
    endtask

    function automatic logic [4:0] selOf(input int o);
        return {2'b00, out_sel_o[o*3 +: 3]};
    endfunction

    // Inputs are driven 2 time units after the rising edge and checked 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic resetDut();
        rst_ni      = 1'b0;
        req_valid_i = '0;
        req_port_i  = '0;
        req_tail_i  = '0;
        out_ready_i = '1;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        #50000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int owners [4] = '{0, 1, 3, 0};

        // Reset with random inputs
        rst_ni = 1'b0;
        for (int r = 0; r < 3; r++) begin
            req_valid_i = 5'($urandom);
            req_port_i  = 25'($urandom);
            req_tail_i  = 5'($urandom);
            out_ready_i = 5'($urandom);
            #7;
            checkOutput("rst_grant", grant_o, 5'b0);
            checkOutput("rst_busy", out_busy_o, 5'b0);
            checkOutput("rst_valid", out_valid_o, 5'b0);
            checkOutput("rst_selE", selOf(PE), 5'd0);
            checkOutput("rst_selL", selOf(PL), 5'd0);
        end
        req_valid_i = '0;
        req_port_i  = '0;
        req_tail_i  = '0;
        out_ready_i = '1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();

        // Single-flit packet from input 2 to E
        applyStimulus(2, mE, 1'b1, 1'b1);
        #1;
        checkOutput("single_busy_before", out_busy_o, 5'b0);
        tick();
        #1;
        checkOutput("single_busy", out_busy_o, mE);
        checkOutput("single_grant", grant_o, 5'b00100);
        checkOutput("single_sel", selOf(PE), 5'd2);
        checkOutput("single_valid", out_valid_o, mE);
        tick();
        applyStimulus(2, 5'b0, 1'b0, 1'b0);
        #1;
        checkOutput("single_idle_busy", out_busy_o, 5'b0);
        checkOutput("single_idle_valid", out_valid_o, 5'b0);
        checkOutput("single_idle_grant", grant_o, 5'b0);

        // Contention on S with 2-flit packets from inputs 0, 1, 3
        resetDut();
        applyStimulus(0, mS, 1'b0, 1'b1);
        applyStimulus(1, mS, 1'b0, 1'b1);
        applyStimulus(3, mS, 1'b0, 1'b1);
        for (int p = 0; p < 4; p++) begin
            #1;
            checkOutput("cont_idle_busy", out_busy_o, 5'b0);
            checkOutput("cont_idle_valid", out_valid_o, 5'b0);
            tick();
            #1;
            checkOutput("cont_f1_sel", selOf(PS), 5'(owners[p]));
            checkOutput("cont_f1_grant", grant_o, 5'(1 << owners[p]));
            checkOutput("cont_f1_valid", out_valid_o, mS);
            tick();
            req_tail_i[owners[p]] = 1'b1;
            #1;
            checkOutput("cont_f2_sel", selOf(PS), 5'(owners[p]));
            checkOutput("cont_f2_grant", grant_o, 5'(1 << owners[p]));
            checkOutput("cont_f2_valid", out_valid_o, mS);
            tick();
            req_tail_i[owners[p]] = 1'b0;
        end

        // Backpressure on W while input 1 owns it
        resetDut();
        applyStimulus(1, mW, 1'b0, 1'b1);
        tick();
        #1;
        checkOutput("bp_first_grant", grant_o, 5'b00010);
        checkOutput("bp_first_valid", out_valid_o, mW);
        tick();
        req_tail_i[1]   = 1'b1;
        out_ready_i[PW] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("bp_stall_grant", grant_o, 5'b0);
            checkOutput("bp_stall_busy", out_busy_o, mW);
            checkOutput("bp_stall_valid", out_valid_o, 5'b0);
            tick();
        end
        out_ready_i[PW] = 1'b1;
        #1;
        checkOutput("bp_tail_grant", grant_o, 5'b00010);
        checkOutput("bp_tail_valid", out_valid_o, mW);
        tick();
        applyStimulus(1, 5'b0, 1'b0, 1'b0);
        #1;
        checkOutput("bp_release_busy", out_busy_o, 5'b0);

        // Bubble from owner 0 on L while input 4 waits
        resetDut();
        applyStimulus(0, mL, 1'b0, 1'b1);
        applyStimulus(4, mL, 1'b1, 1'b1);
        tick();
        #1;
        checkOutput("bub_sel", selOf(PL), 5'd0);
        checkOutput("bub_grant", grant_o, 5'b00001);
        checkOutput("bub_valid", out_valid_o, mL);
        tick();
        req_valid_i[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput("bub_hold_grant", grant_o, 5'b00001);
            checkOutput("bub_hold_busy", out_busy_o, mL);
            checkOutput("bub_hold_valid", out_valid_o, 5'b0);
            tick();
        end
        req_valid_i[0] = 1'b1;
        req_tail_i[0]  = 1'b1;
        #1;
        checkOutput("bub_tail_valid", out_valid_o, mL);
        checkOutput("bub_tail_sel", selOf(PL), 5'd0);
        tick();
        applyStimulus(0, 5'b0, 1'b0, 1'b0);
        #1;
        checkOutput("bub_gap_busy", out_busy_o, 5'b0);
        checkOutput("bub_gap_grant", grant_o, 5'b0);
        tick();
        #1;
        checkOutput("bub_next_busy", out_busy_o, mL);
        checkOutput("bub_next_sel", selOf(PL), 5'd4);
        checkOutput("bub_next_grant", grant_o, 5'b10000);

        // Parallel allocation; input 1 uses a multi-bit slice whose lowest bit is N
        resetDut();
        applyStimulus(0, mE, 1'b0, 1'b1);
        applyStimulus(1, mN | mS | mL, 1'b0, 1'b1);
        applyStimulus(2, mL, 1'b0, 1'b1);
        #1;
        checkOutput("par_busy_before", out_busy_o, 5'b0);
        tick();
        #1;
        checkOutput("par_busy", out_busy_o, 5'b10101);
        checkOutput("par_grant", grant_o, 5'b00111);
        checkOutput("par_selE", selOf(PE), 5'd0);
        checkOutput("par_selN", selOf(PN), 5'd1);
        checkOutput("par_selL", selOf(PL), 5'd2);
        checkOutput("par_valid", out_valid_o, 5'b10101);
        tick();
        req_tail_i[1] = 1'b1;
        #1;
        checkOutput("par_tail_valid", out_valid_o, 5'b10101);
        tick();
        applyStimulus(1, 5'b0, 1'b0, 1'b0);
        applyStimulus(0, mN, 1'b0, 1'b1);
        #1;
        checkOutput("par_nfree_busy", out_busy_o, 5'b10001);
        tick();
        #1;
        checkOutput("par_owner_ignored_busy", out_busy_o, 5'b10001);
        checkOutput("par_owner_ignored_grant", grant_o, 5'b00101);
        checkOutput("par_selN_hold", selOf(PN), 5'd1);
        tick();
        #1;
        checkOutput("par_owner_ignored_busy2", out_busy_o, 5'b10001);

        // Reset mid-packet; pointer must return to favouring input 0 over 4
        resetDut();
        applyStimulus(3, mE, 1'b0, 1'b1);
        tick();
        #1;
        checkOutput("rmid_busy", out_busy_o, mE);
        checkOutput("rmid_grant", grant_o, 5'b01000);
        rst_ni = 1'b0;
        #1;
        checkOutput("rmid_async_busy", out_busy_o, 5'b0);
        checkOutput("rmid_async_grant", grant_o, 5'b0);
        checkOutput("rmid_async_sel", selOf(PE), 5'd0);
        applyStimulus(0, mE, 1'b0, 1'b1);
        applyStimulus(4, mE, 1'b0, 1'b1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        #1;
        checkOutput("rmid_after_busy", out_busy_o, mE);
        checkOutput("rmid_after_sel", selOf(PE), 5'd0);
        checkOutput("rmid_after_grant", grant_o, 5'b00001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
